// File: rtl/sd_spi_engine.sv
`timescale 1ns/1ps
// sd_spi_engine: byte-level SPI master (mode 0) for the SD card pins; runs one
// primitive per request: power-up clocking, chip-select control or an 8-bit transfer.
module sd_spi_engine #(
    parameter int SLOW_DIV   = 63,
    parameter int FAST_DIV   = 1,
    parameter int INIT_BYTES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic [2:0] spi_op_i,
    input  logic       spi_fast_i,
    input  logic [7:0] spi_txd_i,
    output logic [7:0] spi_rxd_o,
    output logic       spi_busy_o,
    output logic       spi_done_o,
    input  logic       sd_miso_i,
    output logic       sd_mosi_o,
    output logic       sd_sclk_o,
    output logic       sd_cs_o
);
    localparam int DM = SLOW_DIV > FAST_DIV ? SLOW_DIV : FAST_DIV;
    localparam int DW = $clog2(DM + 2);
    localparam int BW = $clog2(INIT_BYTES + 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(INIT_BYTES - 1);
    localparam logic [2:0] OP_INIT = 3'b001;
    localparam logic [2:0] OP_CSL  = 3'b010;
    localparam logic [2:0] OP_CSH  = 3'b011;
    localparam logic [2:0] OP_XFER = 3'b100;

    typedef enum logic [2:0] {IDLE, CSOP, LOW, HIGH, NEXT, DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    sr_q, sr_d, rx_q, rx_d, rxd_q, rxd_d;
    logic [DW-1:0] div_q, div_d, dsel_q, dsel_d, dnew;
    logic [2:0]    bit_q, bit_d;
    logic [BW-1:0] byte_q, byte_d;
    logic          sclk_q, sclk_d, cs_q, cs_d, init_q, init_d;

    assign dnew = spi_fast_i ? DW'(FAST_DIV) : DW'(SLOW_DIV);

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        rxd_d   = rxd_q;
        div_d   = div_q;
        dsel_d  = dsel_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sclk_d  = sclk_q;
        cs_d    = cs_q;
        init_d  = init_q;
        unique case (state_q)
            IDLE: begin
                if (spi_op_i == OP_CSL || spi_op_i == OP_CSH) begin
                    cs_d    = spi_op_i == OP_CSH;
                    state_d = CSOP;
                end else if (spi_op_i == OP_INIT || spi_op_i == OP_XFER) begin
                    init_d  = spi_op_i == OP_INIT;
                    cs_d    = spi_op_i == OP_INIT ? 1'b1 : cs_q;
                    sr_d    = spi_op_i == OP_INIT ? 8'hFF : spi_txd_i;
                    div_d   = dnew;
                    dsel_d  = dnew;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = LOW;
                end
            end
            CSOP: state_d = DONE;
            LOW, NEXT: begin
                // NEXT is the first low phase of a follow-on INIT byte, so SCLK keeps its period
                sr_d = state_q == NEXT ? 8'hFF : sr_q;
                if (div_q == '0) begin
                    sclk_d  = 1'b1;
                    rx_d    = {rx_q[6:0], sd_miso_i};
                    div_d   = dsel_q;
                    state_d = HIGH;
                end else begin
                    div_d   = div_q - 1'b1;
                    state_d = LOW;
                end
            end
            HIGH: begin
                if (div_q == '0) begin
                    sclk_d = 1'b0;
                    div_d  = dsel_q;
                    bit_d  = bit_q + 3'd1;
                    if (bit_q != 3'd7) begin
                        sr_d    = {sr_q[6:0], 1'b1};
                        state_d = LOW;
                    end else if (init_q && byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = NEXT;
                    end else begin
                        sr_d    = 8'hFF;
                        rxd_d   = init_q ? rxd_q : rx_q;
                        state_d = DONE;
                    end
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clear_i) begin
            state_q <= IDLE;
            sr_q    <= 8'hFF;
            rx_q    <= '0;
            rxd_q   <= '0;
            div_q   <= '0;
            dsel_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            rxd_q   <= rxd_d;
            div_q   <= div_d;
            dsel_q  <= dsel_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            init_q  <= init_d;
        end
    end

    assign spi_rxd_o  = rxd_q;
    assign spi_busy_o = state_q != IDLE && state_q != DONE;
    assign spi_done_o = state_q == DONE;
    assign sd_mosi_o  = sr_q[7];
    assign sd_sclk_o  = sclk_q;
    assign sd_cs_o    = cs_q;
endmodule

// File: doc/sd_spi_engine.md
Name: sd_spi_engine

Overview:
- Byte-level SPI master that sits directly downstream of the SD card controller used by the RK8-E disk emulation.
- Owns the sdMISO/sdMOSI/sdSCLK/sdCS pins.
- Executes single primitive operations on request: card power-up clocking, chip-select control, and 8-bit full-duplex transfers at slow or fast speed.
- The SD command/sector sequencer above it builds CMD0/CMD17/CMD24 framing entirely from these primitives.

Parameters:
- SLOW_DIV, 63: SCLK half-period minus one, in clk cycles, for slow speed (card init, ≤400 kHz).
- FAST_DIV, 1: SCLK half-period minus one, in clk cycles, for fast speed.
- INIT_BYTES, 10: number of 0xFF bytes clocked with CS high during INIT (10 gives 80 SCLKs).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- clear  in  1  IOCLR; synchronous abort, active-high
- spiOP  in  3  operation: 000 NOP, 001 INIT, 010 CSL (assert CS), 011 CSH (deassert CS), 100 XFER
- spiFAST  in  1  speed for INIT/XFER, sampled at accept: 1 selects FAST_DIV, 0 selects SLOW_DIV
- spiTXD  in  8  byte to send, sampled at accept
- spiRXD  out  8  last received byte, valid from spiDONE until the next accepted XFER
- spiBUSY  out  1  operation in progress
- spiDONE  out  1  one-cycle completion pulse
- sdMISO  in  1  card data out
- sdMOSI  out  1  card data in
- sdSCLK  out  1  SPI clock
- sdCS  out  1  chip select, active-low

Behaviour:
- Reset (reset==0 at a clk edge) and clear==1 give identical results:
  - state IDLE, sdCS=1, sdSCLK=0, sdMOSI=1, spiBUSY=0, spiDONE=0, spiRXD=8'h00, counters zero.
  - clear mid-transfer aborts at once, with no spiDONE pulse.
  - reset takes priority over clear.
- SPI mode 0:
  - SCLK idles low.
  - MOSI is updated while SCLK is low.
  - MISO is sampled on the clk edge that drives SCLK high.
  - MSB first.
- Accept rule: an operation is accepted only in IDLE with spiOP≠000. spiOP is ignored while spiBUSY=1 and on the accept cycle's successors. Accept on cycle 0 sets spiBUSY=1 from cycle 1.
- States: IDLE, CSOP, LOW, HIGH, NEXT, DONE.
- CSL/CSH:
  - IDLE→CSOP: sdCS is updated at cycle 1.
  - CSOP→DONE: spiDONE=1 at cycle 2, spiBUSY=0 at cycle 2.
  - IDLE at cycle 3.
- XFER:
  - Cycle 1: shift register is loaded with spiTXD, sdMOSI=spiTXD[7], divider is loaded with D (FAST_DIV or SLOW_DIV), state LOW.
  - LOW lasts D+1 cycles, then → HIGH: sdSCLK=1 and the MISO bit is shifted into the receive register.
  - HIGH lasts D+1 cycles, then: if bits sent <8, → LOW with sdSCLK=0 and sdMOSI = next bit; else → DONE with sdSCLK=0.
  - DONE: spiDONE=1, spiRXD = received byte, spiBUSY=0, sdMOSI=1. Next state IDLE.
  - spiDONE asserts exactly 16·(D+1)+1 cycles after accept: 33 cycles with FAST_DIV=1, 1025 cycles with SLOW_DIV=63.
- INIT:
  - Forces sdCS=1 and transmits INIT_BYTES × 0xFF back-to-back at the selected speed.
  - No idle gap between bytes: the NEXT state reloads the shift register within the last HIGH→LOW transition, so SCLK stays periodic.
  - A single spiDONE is issued after the final byte. spiRXD is unchanged by INIT.
  - Total 80 SCLK rising edges with default INIT_BYTES.
- sdCS is changed only by CSL, CSH, INIT, reset and clear. XFER never touches sdCS.
- Bit counter is 3 bits and wraps only at byte end. Byte counter is sized by clog2(INIT_BYTES+1). No overflow is possible.
- Simultaneous clear and accept: clear wins and the operation is not accepted.

Test Plan:
- reset low for 2 cycles, then release → sdCS=1, sdSCLK=0, sdMOSI=1, spiBUSY=0, spiRXD=00. spiOP=010 → sdCS=0 at cycle 1, spiDONE pulse at cycle 2.
- XFER fast, spiTXD=8'hA5, sdMISO looped to sdMOSI → MOSI sequence 1,0,1,0,0,1,0,1 sampled at SCLK rises; spiDONE at cycle 33; spiRXD=8'hA5; exactly 8 SCLK rises.
- XFER slow, spiTXD=8'hFF, sdMISO driven with 8'h3C MSB-first, changing on SCLK fall → spiRXD=8'h3C; spiDONE at cycle 1025; SCLK high/low periods 64 cycles each.
- INIT fast with sdCS previously 0 → sdCS=1 throughout; sdMOSI=1 throughout; 80 SCLK rises with constant 4-cycle period; one spiDONE; spiRXD unchanged.
- XFER in progress, then spiOP=011 pulsed at cycle 10 → ignored, sdCS unchanged. clear at cycle 20 → next cycle sdSCLK=0, sdCS=1, spiBUSY=0, no spiDONE.
- reset asserted mid-INIT → all outputs at reset values on the next clk edge. A subsequent XFER works normally.
